// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared ALU opcode map and arbiter FSM state encodings.
package alu_arbiter_pkg;
    localparam int ALU_OP_W = 4;

    typedef logic [ALU_OP_W-1:0] alu_op_t;
    typedef logic [1:0]          arb_state_t;

    localparam alu_op_t ALU_ADD  = 4'd0;
    localparam alu_op_t ALU_SUB  = 4'd1;
    localparam alu_op_t ALU_AND  = 4'd2;
    localparam alu_op_t ALU_OR   = 4'd3;
    localparam alu_op_t ALU_XOR  = 4'd4;
    localparam alu_op_t ALU_SLL  = 4'd5;
    localparam alu_op_t ALU_SRL  = 4'd6;
    localparam alu_op_t ALU_SRA  = 4'd7;
    localparam alu_op_t ALU_SLT  = 4'd8;
    localparam alu_op_t ALU_SLTU = 4'd9;
    localparam alu_op_t ALU_EQ   = 4'd10;

    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_EXEC = 2'd1;
    localparam arb_state_t ARB_RESP = 2'd2;
endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or above i_ptr, wrapping.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx
);
    logic w_found;
    int   w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos[$clog2(N)-1:0];
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between NUM_REQ requesters,
// one operation in flight, result held until its owner accepts it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int OP_W    = ALU_OP_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   i_req_op,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
    output logic [DATA_W-1:0]         o_alu_in0,
    output logic [DATA_W-1:0]         o_alu_in1,
    output logic [OP_W-1:0]           o_alu_op_type,
    input  logic [DATA_W-1:0]         i_alu_out,
    output logic [NUM_REQ-1:0]        o_resp_valid,
    input  logic [NUM_REQ-1:0]        i_resp_ready,
    output logic [DATA_W-1:0]         o_resp_data,
    output logic                      o_busy
);
    localparam int PW = $clog2(NUM_REQ);

    arb_state_t         r_state, w_state_nxt;
    logic [PW-1:0]      r_ptr, r_owner, w_idx, w_ptr_nxt;
    logic [NUM_REQ-1:0] w_grant;
    logic [DATA_W-1:0]  r_in0, r_in1, r_data;
    logic [OP_W-1:0]    r_op;
    logic               w_hs;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Gated by reset too, so no grant is offered while the block is held in reset.
    assign o_req_ready = (r_state == ARB_IDLE && !i_flush && i_rst_n) ? w_grant : '0;
    assign w_hs        = |(o_req_ready & i_req_valid);
    assign w_ptr_nxt   = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    assign w_state_nxt = i_flush                   ? ARB_IDLE
                       : (r_state == ARB_IDLE)     ? (w_hs ? ARB_EXEC : ARB_IDLE)
                       : (r_state == ARB_EXEC)     ? ARB_RESP
                       : (r_state == ARB_RESP && !i_resp_ready[r_owner]) ? ARB_RESP
                       : ARB_IDLE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_in0   <= '0;
            r_in1   <= '0;
            r_op    <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_op    <= i_req_op[w_idx*OP_W +: OP_W];
                r_in0   <= i_req_a[w_idx*DATA_W +: DATA_W];
                r_in1   <= i_req_b[w_idx*DATA_W +: DATA_W];
                r_owner <= w_idx;
                r_ptr   <= w_ptr_nxt;
            end
            if (r_state == ARB_EXEC && !i_flush)
                r_data <= i_alu_out;
        end
    end

    assign o_alu_in0     = r_in0;
    assign o_alu_in1     = r_in1;
    assign o_alu_op_type = r_op;
    assign o_resp_data   = r_data;
    assign o_resp_valid  = (r_state == ARB_RESP) ? NUM_REQ'(1) << r_owner : '0;
    assign o_busy        = r_state != ARB_IDLE;
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between NUM_REQ requesters, for example the execute stage and the branch/address-compare path.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- A round-robin grant picks one request, registers its operands and opcode into the ALU input, captures alu_out one cycle later, and holds it until the owner accepts it.
- Only one operation is in flight at a time.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- DATA_W, 32: operand and result width.
- OP_W, 4: width of ALU opcode (ALU_* encoding).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- flush  in  1  synchronous abort of in-flight operation
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accepted (one-hot or zero)
- req_op  in  NUM_REQ*OP_W  flattened opcodes, requester i at [i*OP_W +: OP_W]
- req_a  in  NUM_REQ*DATA_W  flattened operand 0
- req_b  in  NUM_REQ*DATA_W  flattened operand 1
- alu_in0  out  DATA_W  to shared ALU operand 0
- alu_in1  out  DATA_W  to shared ALU operand 1
- alu_op_type  out  OP_W  to shared ALU opcode
- alu_out  in  DATA_W  combinational ALU result
- resp_valid  out  NUM_REQ  one-hot result valid to owner
- resp_ready  in  NUM_REQ  per-requester result accept
- resp_data  out  DATA_W  result, shared by all requesters
- busy  out  1  high when state != IDLE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - req_ready, resp_valid, alu_in0, alu_in1, alu_op_type and resp_data are 0. busy is 0.
  - Round-robin pointer is 0, so requester 0 has highest priority.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is asserted combinationally for exactly one requester: the first set bit of req_valid, searching from the pointer upward with wrap.
  - On a handshake (req_valid[g] & req_ready[g]), the following are registered: req_op into alu_op_type, req_a into alu_in0, req_b into alu_in1, g into owner.
  - Pointer becomes (g+1) mod NUM_REQ. Next state is EXEC.
  - With no valid request, the state and pointer hold.
- EXEC: resp_data <= alu_out. Next state is RESP.
- RESP:
  - resp_valid[owner] is 1. resp_data is stable.
  - On resp_ready[owner], resp_valid drops next cycle and the state returns to IDLE.
  - resp_ready bits of non-owners are ignored.
- req_ready is 0 in EXEC and RESP.
- Minimum spacing between grants is 3 cycles:
  - Handshake at cycle N.
  - resp_valid at N+2.
  - If accepted at N+2, the next grant is at N+3.
- alu_in0, alu_in1 and alu_op_type hold their values outside IDLE handshakes, so the ALU inputs stay stable through EXEC and RESP.
- Opcodes pass through unmodified. Undefined opcodes yield whatever the ALU returns (0).
- flush:
  - In any state, flush forces IDLE next cycle and clears resp_valid.
  - The result is discarded. The pointer keeps its value.
  - In IDLE, flush suppresses req_ready that cycle: no grant.
- Simultaneous requests: round-robin is fair. Under constant contention from all requesters, each is granted once per NUM_REQ grants.
- A requester may drop req_valid before it is granted, with no side effect.
- rst_n assertion mid-operation:
  - Asynchronously returns everything to reset values.
  - resp_valid drops immediately. No response is ever delivered for the aborted operation.

Decomposition:
- ALU_* opcode constants and OP_W come from the shared cpu.vh. Add ARB_IDLE/ARB_EXEC/ARB_RESP state encodings there.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr[clog2 N].
  - Outputs: one-hot grant, encoded grant index.
  - Purely combinational, reusable by later bus arbitration.

Test Plan:
- Single request:
  - Stimulus: requester 0, op=ALU_ADD, a=32'h0000_0005, b=32'h0000_0007, handshake at cycle N, resp_ready held high.
  - Required: resp_valid=2'b01 at N+2 with resp_data=32'h0000_000C; busy low at N+3.
- Contention:
  - Stimulus: both requesters valid continuously; req 0 op=ALU_SUB a=10 b=3; req 1 op=ALU_XOR a=32'hFF b=32'h0F.
  - Required: grants alternate 0,1,0,1. Responses are 7 on resp_valid[0] and 32'hF0 on resp_valid[1], each arriving 3 cycles apart.
- Backpressure:
  - Stimulus: req 1 op=ALU_SRA a=32'h8000_0000 b=4; resp_ready[1] low for 5 cycles.
  - Required: resp_data=32'hF800_0000 held stable; req_ready=0 throughout; completes on the cycle resp_ready[1] rises.
- Flush:
  - Stimulus: assert flush in EXEC for a granted ALU_EQ.
  - Required: resp_valid never asserts; state IDLE next cycle; the next request is granted normally.
- Async reset:
  - Stimulus: drop rst_n while in RESP.
  - Required: resp_valid, busy and req_ready are 0 immediately. After release, requester 0 has priority over a simultaneous requester 1.
- Ignored wrong-owner ready:
  - Stimulus: in RESP for owner 0, assert only resp_ready[1].
  - Required: resp_valid[0] stays high and the state remains RESP.
